input_bit_slicer: RTL
=====================

INPUT_BIT_SLICER -- requirements
Module: input_bit_slicer

Interface
REQ-001 SHALL have parameter N_ROWS, default 8, number of wordline rows driven per slice.
REQ-002 SHALL have parameter BITS, default 4, activation width in bits (slices per frame).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 SHALL have port in_valid  input  1  producer offers one activation vector.
REQ-006 SHALL have port in_data  input  N_ROWS*BITS  activation vector; row r occupies bits [r*BITS +: BITS].
REQ-007 SHALL have port in_ready  output  1  slicer can accept a vector this cycle.
REQ-008 SHALL have port wl_bits  output  N_ROWS  current bit-slice; bit r is one bit of row r.
REQ-009 SHALL have port slice_valid  output  1  wl_bits valid this cycle.
REQ-010 SHALL have port slice_idx  output  clog2(BITS)  0 = MSB slice, BITS-1 = LSB slice.
REQ-011 SHALL have port slice_last  output  1  high with the LSB slice.
REQ-012 SHALL have port slice_zero  output  1  wl_bits all zero while slice_valid (sparsity gate for the adder tree).

Function
REQ-013 SHALL transfer a vector only on a cycle with in_valid and in_ready both high.
REQ-014 SHALL hold one working register plus one pending register; in_ready SHALL equal NOT pending_full, derived from registers only.
REQ-015 SHALL have FSM states IDLE and SLICE; IDLE -> SLICE on accept; SLICE stays until the LSB slice is emitted.
REQ-016 SHALL route an accepted vector to the working register when in IDLE, or in SLICE on the LSB-slice cycle with pending empty; otherwise to the pending register.
REQ-017 SHALL emit the first (MSB) slice the cycle after the vector is loaded into the working register (latency 1).
REQ-018 SHALL emit exactly BITS consecutive slices per vector, MSB first: slice k carries bit (BITS-1-k) of every row.
REQ-019 SHALL drive all slice outputs registered; no combinational path from in_* to wl_bits/slice_*.
REQ-020 On the LSB-slice cycle: pending full -> move pending to working, clear pending, next cycle slice_idx=0 (no bubble); pending empty with accept -> load directly, no bubble; else -> IDLE, slice_valid low next cycle.
REQ-021 SHALL drive slice_last high iff slice_valid and slice_idx = BITS-1.
REQ-022 SHALL drive slice_zero = slice_valid AND (wl_bits = 0).
REQ-023 SHALL, when slice_valid is low, drive wl_bits, slice_idx, slice_last and slice_zero to 0.
REQ-024 SHALL NOT support backpressure on the slice side; the consumer samples every slice_valid cycle.
REQ-025 SHALL ignore in_data when in_ready is low; the pending register SHALL NOT be overwritten.

Reset
REQ-026 While rst is low at a clk edge: FSM -> IDLE; working and pending registers cleared; pending_full = 0.
REQ-027 Reset values: wl_bits=0, slice_valid=0, slice_idx=0, slice_last=0, slice_zero=0; in_ready=1 from the first edge with rst low.
REQ-028 Reset asserted mid-frame SHALL abort the frame: no further slices of that frame or of the pending vector.

Structure
REQ-029 Shared package cim_pkg SHALL hold BITS, N_ROWS defaults and the FSM state type; the consuming shift-accumulator SHALL use the same BITS.
REQ-030 A single sub-module slice_select (combinational N_ROWS-bit extraction of bit position p) is permitted; otherwise flat.

Verification (N_ROWS=8, BITS=4)
REQ-031 All rows 4'b1010, one accept -> wl_bits 0xFF, 0x00, 0xFF, 0x00 on idx 0..3; slice_zero high on idx 1 and 3; slice_last on idx 3; then IDLE.
REQ-032 Row0=4'hF, others 0 -> wl_bits 0x01 on four consecutive cycles, first slice one cycle after accept.
REQ-033 in_valid held high with three distinct vectors -> 12 consecutive slice_valid cycles, no bubble; in_ready low while pending full.
REQ-034 Vector offered while pending full -> not accepted, in_ready low; accepted on the cycle in_ready returns high, data intact.
REQ-035 rst driven low at slice_idx=1 with a pending vector -> next cycle all outputs 0, in_ready=1; no stale slices after release.
REQ-036 All-zero vector -> four slices with wl_bits=0x00, slice_zero=1 on all four.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared constants and FSM state type for the compute-in-memory input path.
// The shift-accumulator downstream uses CIM_BITS so both ends agree on slices per frame.
package cim_pkg;

    localparam int CIM_BITS   = 4;
    localparam int CIM_N_ROWS = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SLICE = 1'b1
    } slicer_state_t;

endpackage

// File: rtl/slice_select.sv
// Combinational extraction of bit position pos_i from every BITS-wide row.
// Row r occupies data_i[r*BITS +: BITS]; its selected bit lands on bits_o[r].
module slice_select #(
    parameter int N_ROWS = 8,
    parameter int BITS   = 4,
    localparam int POS_W = (BITS > 1) ? $clog2(BITS) : 1
) (
    input  logic [N_ROWS*BITS-1:0] data_i,
    input  logic [POS_W-1:0]       pos_i,
    output logic [N_ROWS-1:0]      bits_o
);

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        logic [BITS-1:0] row;
        assign row       = data_i[r*BITS +: BITS];
        assign bits_o[r] = row[pos_i];
    end

endmodule

// File: rtl/input_bit_slicer.sv
// Serialises activation vectors into BITS wordline bit-slices, MSB first.
// One working and one pending register give back-to-back frames with no bubble.
module input_bit_slicer
    import cim_pkg::*;
#(
    parameter int N_ROWS = CIM_N_ROWS,
    parameter int BITS   = CIM_BITS,
    localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_ROWS*BITS-1:0] in_data,
    output logic                   in_ready,
    output logic [N_ROWS-1:0]      wl_bits,
    output logic                   slice_valid,
    output logic [IDX_W-1:0]       slice_idx,
    output logic                   slice_last,
    output logic                   slice_zero,
    output logic                   dbg_state
);

    localparam int                 VEC_W   = N_ROWS * BITS;
    localparam logic [IDX_W-1:0]   LSB_IDX = IDX_W'(BITS - 1);

    // Handshake: a vector moves only on a cycle where in_valid and in_ready are
    // both high; in_ready depends on registers only, so the producer may use it
    // to decide in_valid without forming a loop.

    slicer_state_t       state_q, state_d;
    logic [VEC_W-1:0]    work_q, work_d;
    logic [VEC_W-1:0]    pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_ROWS-1:0]   wl_q, wl_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                zero_q, zero_d;

    logic                accept;
    logic                lsb_cycle;
    logic [IDX_W-1:0]    pos_d;
    logic [N_ROWS-1:0]   sel_bits;

    assign in_ready  = ~pend_full_q;
    assign accept    = in_valid & ~pend_full_q;
    assign lsb_cycle = (state_q == ST_SLICE) && (idx_q == LSB_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            wl_q        <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            wl_q        <= wl_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (accept) begin
                    work_d  = in_data;
                    state_d = ST_SLICE;
                end
            end
            ST_SLICE: begin
                if (!lsb_cycle) begin
                    idx_d = idx_q + 1'b1;
                    if (accept) begin
                        pend_d      = in_data;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    work_d      = pend_q;
                    pend_d      = '0;
                    pend_full_d = 1'b0;
                    idx_d       = '0;
                end else if (accept) begin
                    work_d = in_data;
                    idx_d  = '0;
                end else begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slice outputs are computed from next-state values and flopped, so the
    // first slice appears the cycle right after the working register loads.
    slice_select #(
        .N_ROWS (N_ROWS),
        .BITS   (BITS)
    ) u_slice_select (
        .data_i (work_d),
        .pos_i  (pos_d),
        .bits_o (sel_bits)
    );

    always_comb begin
        pos_d   = LSB_IDX - idx_d;
        valid_d = (state_d == ST_SLICE);
        wl_d    = valid_d ? sel_bits : '0;
        last_d  = valid_d && (idx_d == LSB_IDX);
        zero_d  = valid_d && (sel_bits == '0);
    end

    assign wl_bits     = wl_q;
    assign slice_valid = valid_q;
    assign slice_idx   = idx_q;
    assign slice_last  = last_q;
    assign slice_zero  = zero_q;
    assign dbg_state   = state_q;

endmodule
